// File: rtl/lu_share_pkg.sv
// Shared types and constants for the lu_share_ctrl logic-lane sharing controller.
package lu_share_pkg;

  localparam int LU_DEF_LANE_W = 8;
  localparam int LU_DEF_DATA_W = 16;

  localparam logic [1:0] LU_XOR  = 2'b00;
  localparam logic [1:0] LU_AND  = 2'b01;
  localparam logic [1:0] LU_OR   = 2'b10;
  localparam logic [1:0] LU_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PASS = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr_r names the requester that wins the next tie.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_r;
  logic ptr_s;

  // grant selection and pointer update
  always_comb begin
    gnt   = 2'b00;
    ptr_s = ptr_r;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // serving requester 0 hands priority to 1, and vice versa
    if (advance && (gnt != 2'b00)) begin
      ptr_s = gnt[0];
    end else begin
      ptr_s = ptr_r;
    end
  end

  // priority pointer register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_s;
    end
  end

endmodule

// File: rtl/lu_share_ctrl.sv
// Shares one LANE_W logic lane between two requesters, one byte per cycle, low byte first.
// Optional macro LU_ZERO_FLAG_EN adds a Zero output driven by a per-pass sticky all-zero flag.
module lu_share_ctrl
  import lu_share_pkg::*;
#(
  parameter int DATA_W = LU_DEF_DATA_W,
  parameter int LANE_W = LU_DEF_LANE_W
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  input  logic [1:0]        Op0,
  input  logic [1:0]        Op1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] Result,
  output logic [LANE_W-1:0] LU_In1,
  output logic [LANE_W-1:0] LU_In2,
  output logic [1:0]        LU_Op,
  input  logic [LANE_W-1:0] LU_O
`ifdef LU_ZERO_FLAG_EN
  ,
  output logic              Zero
`endif
);

  localparam int PASSES = DATA_W / LANE_W;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              gid_r, gid_s;
  logic [1:0]        op_r, op_s;
  logic [DATA_W-1:0] a_sh_r, a_sh_s;
  logic [DATA_W-1:0] b_sh_r, b_sh_s;
  logic [DATA_W-1:0] res_r, res_s;
  logic [DATA_W-1:0] lane_res_s;
  logic [DATA_W-1:0] opa_s, opb_s;
  logic [1:0]        opc_s;
  logic [1:0]        ack_r, ack_s;
  logic [1:0]        done_r, done_s;
  logic [DATA_W-1:0] result_r, result_s;
  logic [LANE_W-1:0] lu_in1_r, lu_in1_s;
  logic [LANE_W-1:0] lu_in2_r, lu_in2_s;
  logic [1:0]        lu_op_r, lu_op_s;
  logic [1:0]        gnt_s;
  logic              advance_s;
`ifdef LU_ZERO_FLAG_EN
  logic              zacc_r, zacc_s;
  logic              zero_r, zero_s;
`endif

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .req     ({Req1, Req0}),
    .advance (advance_s),
    .gnt     (gnt_s)
  );

  // next-state and next-output computation
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    gid_s     = gid_r;
    op_s      = op_r;
    a_sh_s    = a_sh_r;
    b_sh_s    = b_sh_r;
    res_s     = res_r;
    ack_s     = 2'b00;
    done_s    = 2'b00;
    result_s  = {DATA_W{1'b0}};
    lu_in1_s  = lu_in1_r;
    lu_in2_s  = lu_in2_r;
    lu_op_s   = lu_op_r;
    advance_s = 1'b0;
`ifdef LU_ZERO_FLAG_EN
    zacc_s    = zacc_r;
    zero_s    = 1'b0;
`endif
    opa_s = gnt_s[1] ? A1 : A0;
    opb_s = gnt_s[1] ? B1 : B0;
    opc_s = gnt_s[1] ? Op1 : Op0;
    // the newest lane byte enters at the top; after PASSES shifts byte 0 sits lowest
    lane_res_s = (res_r >> LANE_W) | (DATA_W'(LU_O) << (DATA_W - LANE_W));

    case (state_r)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          advance_s = 1'b1;
          gid_s     = gnt_s[1];
          op_s      = opc_s;
          lu_op_s   = opc_s;
          lu_in1_s  = opa_s[LANE_W-1:0];
          lu_in2_s  = opb_s[LANE_W-1:0];
          a_sh_s    = opa_s >> LANE_W;
          b_sh_s    = opb_s >> LANE_W;
          ack_s     = gnt_s;
          cnt_s     = {CNT_W{1'b0}};
          res_s     = {DATA_W{1'b0}};
`ifdef LU_ZERO_FLAG_EN
          zacc_s    = 1'b1;
`endif
          state_s   = PASS;
        end else begin
          state_s   = IDLE;
        end
      end
      PASS: begin
        res_s = lane_res_s;
`ifdef LU_ZERO_FLAG_EN
        zacc_s = zacc_r & (LU_O == {LANE_W{1'b0}});
`endif
        if (cnt_r == LAST_PASS) begin
          done_s   = gid_r ? 2'b10 : 2'b01;
          result_s = lane_res_s;
`ifdef LU_ZERO_FLAG_EN
          zero_s   = zacc_s;
`endif
          state_s  = DONE;
        end else begin
          cnt_s    = cnt_r + CNT_W'(1);
          lu_in1_s = a_sh_r[LANE_W-1:0];
          lu_in2_s = b_sh_r[LANE_W-1:0];
          a_sh_s   = a_sh_r >> LANE_W;
          b_sh_s   = b_sh_r >> LANE_W;
          state_s  = PASS;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      gid_r    <= 1'b0;
      op_r     <= 2'b00;
      a_sh_r   <= {DATA_W{1'b0}};
      b_sh_r   <= {DATA_W{1'b0}};
      res_r    <= {DATA_W{1'b0}};
      ack_r    <= 2'b00;
      done_r   <= 2'b00;
      result_r <= {DATA_W{1'b0}};
      lu_in1_r <= {LANE_W{1'b0}};
      lu_in2_r <= {LANE_W{1'b0}};
      lu_op_r  <= 2'b00;
`ifdef LU_ZERO_FLAG_EN
      zacc_r   <= 1'b0;
      zero_r   <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      gid_r    <= gid_s;
      op_r     <= op_s;
      a_sh_r   <= a_sh_s;
      b_sh_r   <= b_sh_s;
      res_r    <= res_s;
      ack_r    <= ack_s;
      done_r   <= done_s;
      result_r <= result_s;
      lu_in1_r <= lu_in1_s;
      lu_in2_r <= lu_in2_s;
      lu_op_r  <= lu_op_s;
`ifdef LU_ZERO_FLAG_EN
      zacc_r   <= zacc_s;
      zero_r   <= zero_s;
`endif
    end
  end

  assign Ack0   = ack_r[0];
  assign Ack1   = ack_r[1];
  assign Done0  = done_r[0];
  assign Done1  = done_r[1];
  assign Result = result_r;
  assign LU_In1 = lu_in1_r;
  assign LU_In2 = lu_in2_r;
  assign LU_Op  = lu_op_r;
`ifdef LU_ZERO_FLAG_EN
  assign Zero   = zero_r;
`endif

endmodule

// File: tb/tb_lu_share_ctrl.sv
// Self-checking bench for lu_share_ctrl: directed cases then randomized traffic against a word-level model.
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_lu_share_ctrl;
  import lu_share_pkg::*;

  localparam int DATA_W = 16;
  localparam int LANE_W = 8;
  localparam int PASSES = DATA_W / LANE_W;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              Req0, Req1;
  logic [DATA_W-1:0] A0, B0, A1, B1;
  logic [1:0]        Op0, Op1;
  logic              Ack0, Ack1, Done0, Done1;
  logic [DATA_W-1:0] Result;
  logic [LANE_W-1:0] LU_In1, LU_In2, LU_O;
  logic [1:0]        LU_Op;
`ifdef LU_ZERO_FLAG_EN
  logic              Zero;
`endif

  int tests = 0;
  int fails = 0;
  int prio  = 0;

  lu_share_ctrl #(.DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Op0(Op0), .Op1(Op1),
    .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1),
    .Result(Result),
    .LU_In1(LU_In1), .LU_In2(LU_In2), .LU_Op(LU_Op),
    .LU_O(LU_O)
`ifdef LU_ZERO_FLAG_EN
    , .Zero(Zero)
`endif
  );

  always #5 CLK = ~CLK;

  // combinational shared lane
  always_comb begin
    case (LU_Op)
      LU_XOR:  LU_O = LU_In1 ^ LU_In2;
      LU_AND:  LU_O = LU_In1 & LU_In2;
      LU_OR:   LU_O = LU_In1 | LU_In2;
      default: LU_O = ~(LU_In1 ^ LU_In2);
    endcase
  end

  // protocol monitor: exclusive pulses and zero Result outside Done
  always @(negedge CLK) begin
    if (RST_n) begin
      tests++;
      if ((Done0 & Done1) !== 1'b0) begin
        fails++;
        $error("FAIL mon_done_excl Done0=%0b Done1=%0b", Done0, Done1);
      end
      if ((Ack0 & Ack1) !== 1'b0) begin
        fails++;
        $error("FAIL mon_ack_excl Ack0=%0b Ack1=%0b", Ack0, Ack1);
      end
      if (((Done0 | Done1) === 1'b0) && (Result !== 16'h0000)) begin
        fails++;
        $error("FAIL mon_result_zero Result=%0h", Result);
      end
    end
  end

  function automatic logic [DATA_W-1:0] ref_op(input logic [DATA_W-1:0] a, b, input logic [1:0] op);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // round-robin model: r bit0 = Req0, bit1 = Req1
  function automatic int pick(input int r);
    int w;
    if (r == 3) w = prio;
    else if (r == 2) w = 1;
    else w = 0;
    prio = 1 - w;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    `CHK({tag, "_ack0"}, Ack0, 1'b0);
    `CHK({tag, "_ack1"}, Ack1, 1'b0);
    `CHK({tag, "_done0"}, Done0, 1'b0);
    `CHK({tag, "_done1"}, Done1, 1'b0);
    `CHK({tag, "_result"}, Result, 16'h0000);
`ifdef LU_ZERO_FLAG_EN
    `CHK({tag, "_zero"}, Zero, 1'b0);
`endif
  endtask

  // Current cycle is IDLE with requests set; runs winner w through to the following IDLE cycle.
  task automatic txn(input int w, input logic [DATA_W-1:0] a, b, input logic [1:0] op, input bit drop_all);
    logic [DATA_W-1:0] exp;
    exp = ref_op(a, b, op);
    for (int p = 0; p < PASSES; p++) begin
      tick();
      `CHK("ack0", Ack0, (p == 0) && (w == 0));
      `CHK("ack1", Ack1, (p == 0) && (w == 1));
      `CHK("lu_in1", LU_In1, a[p*LANE_W +: LANE_W]);
      `CHK("lu_in2", LU_In2, b[p*LANE_W +: LANE_W]);
      `CHK("lu_op", LU_Op, op);
      `CHK("pass_done", {Done1, Done0}, 2'b00);
      `CHK("pass_result", Result, 16'h0000);
      if (p == 0) begin
        if (drop_all) begin
          Req0 = 1'b0; Req1 = 1'b0;
        end else if (w == 0) begin
          Req0 = 1'b0;
        end else begin
          Req1 = 1'b0;
        end
        if (w == 0) begin
          A0 = 16'($urandom); B0 = 16'($urandom); Op0 = 2'($urandom_range(0, 3));
        end else begin
          A1 = 16'($urandom); B1 = 16'($urandom); Op1 = 2'($urandom_range(0, 3));
        end
      end
    end
    tick();
    `CHK("done0", Done0, w == 0);
    `CHK("done1", Done1, w == 1);
    `CHK("result", Result, exp);
    `CHK("done_ack", {Ack1, Ack0}, 2'b00);
    `CHK("hold_in1", LU_In1, a[DATA_W-1 -: LANE_W]);
`ifdef LU_ZERO_FLAG_EN
    `CHK("zero", Zero, exp == 16'h0000);
`endif
    tick();
    chk_quiet("idle");
  endtask

  initial begin
    int r, w, w2;
    bit keep;
    RST_n = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    A0 = 16'h0000; B0 = 16'h0000; A1 = 16'h0000; B1 = 16'h0000;
    Op0 = 2'b00; Op1 = 2'b00;
    #2;
    chk_quiet("rst");
    `CHK("rst_in1", LU_In1, 8'h00);
    `CHK("rst_in2", LU_In2, 8'h00);
    `CHK("rst_op", LU_Op, 2'b00);
    tick();
    tick();

    // tie from reset: Req0 first, then Req1 (Ack1 cycle 5, Done1 cycle 7)
    A0 = 16'hF0F0; B0 = 16'h3C3C; Op0 = 2'b01;
    A1 = 16'h5A5A; B1 = 16'hFF0F; Op1 = 2'b01;
    Req0 = 1'b1; Req1 = 1'b1;
    RST_n = 1'b1;
    w = pick(3);
    txn(w, A0, B0, Op0, 1'b0);
    w = pick(2);
    txn(w, A1, B1, Op1, 1'b0);

    A0 = 16'hAAAA; B0 = 16'hAAAA; Op0 = 2'b00; Req0 = 1'b1;
    w = pick(1);
    txn(w, A0, B0, Op0, 1'b0);

    A1 = 16'hAAAA; B1 = 16'h2222; Op1 = 2'b00; Req1 = 1'b1;
    w = pick(2);
    txn(w, A1, B1, Op1, 1'b0);

    A0 = 16'h0F0F; B0 = 16'hFF00; Op0 = 2'b10; Req0 = 1'b1;
    w = pick(1);
    txn(w, A0, B0, Op0, 1'b0);

    // reset during the second pass aborts with no Done
    A0 = 16'h5555; B0 = 16'h0FF0; Op0 = 2'b00; Req0 = 1'b1;
    w = pick(1);
    tick();
    `CHK("abort_ack0", Ack0, 1'b1);
    Req0 = 1'b0;
    tick();
    RST_n = 1'b0;
    prio = 0;
    #1;
    chk_quiet("abort");
    `CHK("abort_in1", LU_In1, 8'h00);
    `CHK("abort_op", LU_Op, 2'b00);
    tick();
    chk_quiet("abort_hold");
    RST_n = 1'b1;
    tick();
    chk_quiet("abort_post1");
    tick();
    chk_quiet("abort_post2");

    A0 = 16'h1234; B0 = 16'h1234; Op0 = 2'b11; Req0 = 1'b1;
    w = pick(1);
    txn(w, A0, B0, Op0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(1, 3));
      keep = 1'($urandom_range(0, 1));
      A0 = 16'($urandom); B0 = 16'($urandom); Op0 = 2'($urandom_range(0, 3));
      A1 = 16'($urandom); B1 = 16'($urandom); Op1 = 2'($urandom_range(0, 3));
      if ((i % 8) == 3) begin
        B0 = A0; Op0 = 2'b00;
      end
      Req0 = r[0]; Req1 = r[1];
      w = pick(r);
      if (w == 0) txn(w, A0, B0, Op0, (r == 3) && !keep);
      else        txn(w, A1, B1, Op1, (r == 3) && !keep);
      if ((r == 3) && keep) begin
        w2 = pick((w == 0) ? 2 : 1);
        if (w2 == 0) txn(w2, A0, B0, Op0, 1'b0);
        else         txn(w2, A1, B1, Op1, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
